// File: rtl/alu_acc_seq.sv
// alu_acc_seq
// W-bit sequential ALU with a valid/ready request handshake, registered
// result and flags, a 2W-bit running accumulator and a shift-add multiplier
// that retires one partial product per cycle.
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_ena        stall when low: no accept, FSM/counters/outputs hold
//   i_in_valid   operation request
//   o_in_ready   block can accept (IDLE and enabled)
//   i_op         operation code (ADD SUB ACC CLR MUL AND XOR RD)
//   i_a, i_b     unsigned W-bit operands
//   o_out_valid  one-cycle pulse: result and flags were updated
//   o_result     registered 2W-bit result, holds between pulses
//   o_carry      carry / borrow / accumulator wrap
//   o_overflow   signed overflow of SUB, otherwise 0
//   o_zero       new result equals zero
//   o_busy       multiply in progress
module alu_acc_seq #(
  parameter int W = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_ena,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic [2:0]     i_op,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_out_valid,
  output logic [2*W-1:0] o_result,
  output logic           o_carry,
  output logic           o_overflow,
  output logic           o_zero,
  output logic           o_busy
);

  localparam int RW = 2 * W;
  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ACC = 3'b010;
  localparam logic [2:0] OP_CLR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  localparam logic [CW-1:0] CNT_INIT = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [RW-1:0] r_acc, w_acc_nxt;
  logic [RW-1:0] r_prod, w_prod_nxt;
  logic [RW-1:0] r_mcand, w_mcand_nxt;
  logic [W-1:0]  r_mplier, w_mplier_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [RW-1:0] r_result, w_result_nxt;
  logic          r_carry, w_carry_nxt;
  logic          r_ovf, w_ovf_nxt;
  logic          r_zero, w_zero_nxt;
  logic          r_out_valid, w_out_valid_nxt;
  logic          r_busy, w_busy_nxt;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_done;
  logic [W:0]    w_sum;
  logic [W:0]    w_diff;
  logic          w_sub_ovf;
  logic [RW:0]   w_acc_sum;
  logic [RW-1:0] w_addend;
  logic [RW-1:0] w_prod_add;

  assign w_in_ready = (r_state == S_IDLE) && i_ena;
  assign w_accept   = i_in_valid && w_in_ready;

  // Operand arithmetic; bit W of the W+1-bit difference is the borrow.
  assign w_sum      = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff     = {1'b0, i_a} - {1'b0, i_b};
  // Signed overflow: operands differ in sign and the result sign differs from a.
  assign w_sub_ovf  = (i_a[W-1] ^ i_b[W-1]) & (w_diff[W-1] ^ i_a[W-1]);
  assign w_acc_sum  = {1'b0, r_acc} + {{(W + 1){1'b0}}, i_a};
  assign w_addend   = r_mplier[0] ? r_mcand : {RW{1'b0}};
  assign w_prod_add = r_prod + w_addend;

  // Next-state, datapath and output-register values.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_prod_nxt      = r_prod;
    w_mcand_nxt     = r_mcand;
    w_mplier_nxt    = r_mplier;
    w_cnt_nxt       = r_cnt;
    w_result_nxt    = r_result;
    w_carry_nxt     = r_carry;
    w_ovf_nxt       = r_ovf;
    w_out_valid_nxt = r_out_valid;
    w_busy_nxt      = r_busy;
    w_done          = 1'b0;

    if (i_ena) begin
      // out_valid is a pulse: it only survives an enabled edge that completes an op.
      w_out_valid_nxt = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (i_op == OP_MUL) begin
              w_prod_nxt   = {RW{1'b0}};
              w_mcand_nxt  = {{W{1'b0}}, i_a};
              w_mplier_nxt = i_b;
              w_cnt_nxt    = CNT_INIT;
              w_busy_nxt   = 1'b1;
              w_state_nxt  = S_MUL;
            end else begin
              w_done      = 1'b1;
              w_carry_nxt = 1'b0;
              w_ovf_nxt   = 1'b0;
              case (i_op)
                OP_ADD: begin
                  w_result_nxt = {{(W - 1){1'b0}}, w_sum};
                  w_carry_nxt  = w_sum[W];
                end
                OP_SUB: begin
                  w_result_nxt = {{W{1'b0}}, w_diff[W-1:0]};
                  w_carry_nxt  = w_diff[W];
                  w_ovf_nxt    = w_sub_ovf;
                end
                OP_ACC: begin
                  w_acc_nxt    = w_acc_sum[RW-1:0];
                  w_result_nxt = w_acc_sum[RW-1:0];
                  w_carry_nxt  = w_acc_sum[RW];
                end
                OP_CLR: begin
                  w_acc_nxt    = {RW{1'b0}};
                  w_result_nxt = {RW{1'b0}};
                end
                OP_AND: w_result_nxt = {{W{1'b0}}, i_a & i_b};
                OP_XOR: w_result_nxt = {{W{1'b0}}, i_a ^ i_b};
                // RD (MUL never reaches this branch)
                default: w_result_nxt = r_acc;
              endcase
            end
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_MUL: begin
          w_prod_nxt   = w_prod_add;
          w_mcand_nxt  = {r_mcand[RW-2:0], 1'b0};
          w_mplier_nxt = {1'b0, r_mplier[W-1:1]};
          w_cnt_nxt    = r_cnt - CNT_ONE;
          // Last partial product: the sum including it is the final product.
          if (r_cnt <= CNT_ONE) begin
            w_done       = 1'b1;
            w_result_nxt = w_prod_add;
            w_carry_nxt  = 1'b0;
            w_ovf_nxt    = 1'b0;
            w_busy_nxt   = 1'b0;
            w_state_nxt  = S_IDLE;
          end else begin
            w_state_nxt = S_MUL;
          end
        end
        default: begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end

    if (w_done) begin
      w_out_valid_nxt = 1'b1;
      w_zero_nxt      = (w_result_nxt == {RW{1'b0}});
    end else begin
      w_zero_nxt = r_zero;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= {RW{1'b0}};
      r_prod      <= {RW{1'b0}};
      r_mcand     <= {RW{1'b0}};
      r_mplier    <= {W{1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_result    <= {RW{1'b0}};
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_prod      <= w_prod_nxt;
      r_mcand     <= w_mcand_nxt;
      r_mplier    <= w_mplier_nxt;
      r_cnt       <= w_cnt_nxt;
      r_result    <= w_result_nxt;
      r_carry     <= w_carry_nxt;
      r_ovf       <= w_ovf_nxt;
      r_zero      <= w_zero_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_carry     = r_carry;
  assign o_overflow  = r_ovf;
  assign o_zero      = r_zero;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_alu_acc_seq.sv
// Testbench for alu_acc_seq (W=4): directed cases from the test plan plus a
// randomized phase; expected responses come from an arithmetic reference
// model and are checked by a queue-based monitor.
module tb_alu_acc_seq;

  localparam int W  = 4;
  localparam int RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic [RW-1:0] result;
  logic          carry;
  logic          overflow;
  logic          zero;
  logic          busy;

  alu_acc_seq #(.W(W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_ena       (ena),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_op        (op),
    .i_a         (a),
    .i_b         (b),
    .o_out_valid (out_valid),
    .o_result    (result),
    .o_carry     (carry),
    .o_overflow  (overflow),
    .o_zero      (zero),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RW-1:0] res;
    logic          c;
    logic          v;
    logic          z;
  } exp_t;

  exp_t   sb_q[$];
  int     n_tests   = 0;
  int     n_fail    = 0;
  int     edge_cnt  = 0;
  logic   edge_en   = 1'b0;
  longint model_acc = 0;
  bit     rand_mode = 1'b0;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    edge_en  <= ena;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: computes the response from the operation rules and queues it.
  function automatic void push_model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint p  = longint'(1) << W;
    longint pr = longint'(1) << RW;
    longint h  = p / 2;
    longint xa = longint'(x);
    longint ya = longint'(y);
    longint r  = 0;
    longint sx, sy, d, s;
    bit c = 1'b0;
    bit v = 1'b0;
    exp_t e;
    case (o)
      3'd0: begin r = xa + ya; c = (r >= p); end
      3'd1: begin
        r  = (xa >= ya) ? (xa - ya) : (xa - ya + p);
        c  = (xa < ya);
        sx = (xa >= h) ? xa - p : xa;
        sy = (ya >= h) ? ya - p : ya;
        d  = sx - sy;
        v  = (d < -h) || (d > h - 1);
      end
      3'd2: begin
        s = model_acc + xa;
        c = (s >= pr);
        model_acc = s % pr;
        r = model_acc;
      end
      3'd3: begin model_acc = 0; r = 0; end
      3'd4: r = xa * ya;
      3'd5: r = xa & ya;
      3'd6: r = xa ^ ya;
      default: r = model_acc;
    endcase
    e.res = r[RW-1:0];
    e.c   = c;
    e.v   = v;
    e.z   = (r == 0);
    sb_q.push_back(e);
  endfunction

  // Monitor: every result presented after an enabled edge must match the queue head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && edge_en && out_valid) begin
      check("sb_nonempty", longint'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_result",   result,   e.res);
        check("sb_carry",    carry,    e.c);
        check("sb_overflow", overflow, e.v);
        check("sb_zero",     zero,     e.z);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until accepted; returns the accept edge number.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int acc_edge);
    bit done = 1'b0;
    acc_edge = -1;
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        push_model(o, x, y);
        #1;
        acc_edge = edge_cnt;
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        if (rand_mode) ena = ($urandom_range(0, 3) != 0);
      end
    end
    in_valid = 1'b0;
    check("accepted", longint'(done), 1);
    if (rand_mode) ena = ($urandom_range(0, 3) != 0);
  endtask

  // Wait for a multiply to finish; busy/in_ready must hold while it runs.
  task automatic wait_done(input int k, output int lat);
    bit done = 1'b0;
    lat = -1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (out_valid && edge_en) begin
        lat  = edge_cnt - k;
        done = 1'b1;
        check("ready_with_pulse", in_ready, 1);
      end else begin
        check("busy_during_mul", busy, 1);
        check("not_ready_during_mul", in_ready, 0);
      end
    end
    check("mul_completed", longint'(done), 1);
  endtask

  task automatic chk_out(input string tag, input longint r, input bit c, input bit v, input bit z);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_result"}, result, r);
    check({tag, "_carry"}, carry, longint'(c));
    check({tag, "_ovf"}, overflow, longint'(v));
    check({tag, "_zero"}, zero, longint'(z));
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_result"}, result, 0);
    check({tag, "_zero"}, zero, 1);
    check({tag, "_carry"}, carry, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got t=%0t expected less", $time);
    $fatal(1);
  end

  initial begin
    int k, k2, kprev, lat;
    rst_n    = 1'b0;
    ena      = 1'b1;
    in_valid = 1'b0;
    op       = 3'd0;
    a        = '0;
    b        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    check("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    sync();

    // ADD 9+8 and single-cycle pulse width
    issue(3'd0, 4'd9, 4'd8, k);
    @(negedge clk);
    chk_out("add", 'h11, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("add_pulse_drop", out_valid, 0);
    check("add_hold", result, 'h11);
    sync();

    // SUB cases
    issue(3'd1, 4'd3, 4'd5, k);
    @(negedge clk);
    chk_out("sub_borrow", 'h0E, 1'b1, 1'b0, 1'b0);
    sync();
    issue(3'd1, 4'd8, 4'd1, k);
    @(negedge clk);
    chk_out("sub_ovf", 'h07, 1'b0, 1'b1, 1'b0);
    sync();
    issue(3'd1, 4'd5, 4'd5, k);
    @(negedge clk);
    chk_out("sub_zero", 0, 1'b0, 1'b0, 1'b1);
    sync();

    // MUL 15*15, no stall
    issue(3'd4, 4'd15, 4'd15, k);
    wait_done(k, lat);
    check("mul_latency", lat, W);
    check("mul_result", result, 'hE1);
    sync();

    // MUL 15*15 with ena low for two cycles mid-operation
    issue(3'd4, 4'd15, 4'd15, k);
    fork
      wait_done(k, lat);
      begin
        @(posedge clk);
        #1 ena = 1'b0;
        repeat (2) @(posedge clk);
        #1 ena = 1'b1;
      end
    join
    check("mul_stall_latency", lat, W + 2);
    check("mul_stall_result", result, 'hE1);
    sync();

    // CLR then 18 back-to-back ACC of 15, then RD
    issue(3'd3, 4'd0, 4'd0, k);
    kprev = k;
    for (int i = 0; i < 18; i++) begin
      issue(3'd2, 4'd15, 4'd0, k);
      check("acc_back_to_back", k - kprev, 1);
      kprev = k;
    end
    @(negedge clk);
    chk_out("acc18", 14, 1'b1, 1'b0, 1'b0);
    sync();
    issue(3'd7, 4'd0, 4'd0, k);
    @(negedge clk);
    chk_out("rd", 14, 1'b0, 1'b0, 1'b0);
    sync();

    // Request held during MUL is taken exactly once when ready returns
    issue(3'd4, 4'd7, 4'd9, k);
    issue(3'd0, 4'd3, 4'd4, k2);
    check("held_accept_edge", k2 - k, W + 1);
    @(negedge clk);
    chk_out("held_add", 7, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("held_once", out_valid, 0);
    sync();

    // Reset in the second cycle of a MUL
    issue(3'd4, 4'd15, 4'd15, k);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    model_acc = 0;
    #1;
    chk_reset_vals("mid_mul_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("ready_after_release", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_pulse_after_abort", out_valid, 0);
    end
    sync();
    issue(3'd0, 4'd1, 4'd1, k);
    @(negedge clk);
    chk_out("add_after_reset", 2, 1'b0, 1'b0, 1'b0);
    sync();

    // Randomized phase with random enable and request gaps
    rand_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) sync();
      issue(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), k);
    end
    rand_mode = 1'b0;
    ena = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
